// File: rtl/alu_y_stage.sv
// Y operand register plus ALU stage feeding the Z result register.
// Optional macro ALU_MUL_EN adds a multi-cycle shift-add MUL (opcode C).
module alu_y_stage #(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             Y_in,
  input  logic [3:0]       alu_op,
  input  logic             alu_start,
  output logic [WIDTH-1:0] to_Z,
  output logic             alu_busy,
  output logic             alu_done,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] REG_OUT_Y,
  output logic [0:0]       dbg_state
);

  localparam int          MSB     = WIDTH - 1;
  localparam logic [0:0]  ST_IDLE = 1'b0;
  localparam logic [0:0]  ST_MUL  = 1'b1;
  localparam logic [3:0]  OP_MUL  = 4'hC;
  localparam logic [WIDTH:0] ONE  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum_w, diff_w, inc_w, dec_w;
  logic [WIDTH-1:0] op_r;
  logic             op_c, op_v;
  logic [3:0]       op_flags;

  // Extra top bit of each extended result is carry-out or borrow.
  assign sum_w  = {1'b0, y_q} + {1'b0, bus_in};
  assign diff_w = {1'b0, y_q} - {1'b0, bus_in};
  assign inc_w  = {1'b0, bus_in} + ONE;
  assign dec_w  = {1'b0, bus_in} - ONE;

  always_comb begin
    op_r = '0;
    op_c = 1'b0;
    op_v = 1'b0;
    case (alu_op)
      4'h0: begin
        op_r = sum_w[MSB:0];
        op_c = sum_w[WIDTH];
        op_v = (y_q[MSB] == bus_in[MSB]) && (sum_w[MSB] != y_q[MSB]);
      end
      4'h1: begin
        op_r = diff_w[MSB:0];
        op_c = diff_w[WIDTH];
        op_v = (y_q[MSB] != bus_in[MSB]) && (diff_w[MSB] != y_q[MSB]);
      end
      4'h2: op_r = y_q & bus_in;
      4'h3: op_r = y_q | bus_in;
      4'h4: op_r = y_q ^ bus_in;
      4'h5: op_r = ~bus_in;
      4'h6: begin
        op_r = {y_q[MSB-1:0], 1'b0};
        op_c = y_q[MSB];
      end
      4'h7: begin
        op_r = {1'b0, y_q[MSB:1]};
        op_c = y_q[0];
      end
      4'h8: begin
        op_r = {y_q[MSB], y_q[MSB:1]};
        op_c = y_q[0];
      end
      4'h9: op_r = bus_in;
      4'hA: begin
        op_r = inc_w[MSB:0];
        op_c = inc_w[WIDTH];
        op_v = !bus_in[MSB] && inc_w[MSB];
      end
      4'hB: begin
        op_r = dec_w[MSB:0];
        op_c = dec_w[WIDTH];
        op_v = bus_in[MSB] && !dec_w[MSB];
      end
      default: op_r = '0;
    endcase
    op_flags = {op_r[MSB], (op_r == '0), op_c, op_v};
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_nx;

  assign acc_nx    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign alu_busy  = (state_q == ST_MUL);
  assign dbg_state = state_q;
`else
  assign alu_busy  = 1'b0;
  assign dbg_state = ST_IDLE;
`endif

  always_comb begin
    y_d     = Y_in ? bus_in : y_q;
    res_d   = res_q;
    flags_d = flags_q;
    done_d  = 1'b0;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (state_q == ST_MUL) begin
      acc_d    = acc_nx;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
        res_d   = acc_nx[MSB:0];
        flags_d = {acc_nx[MSB], (acc_nx[MSB:0] == '0),
                   |acc_nx[2*WIDTH-1:WIDTH], |acc_nx[2*WIDTH-1:WIDTH]};
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    end else if (alu_start) begin
      if (alu_op == OP_MUL) begin
        mcand_d  = {{WIDTH{1'b0}}, y_q};
        mplier_d = bus_in;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = ST_MUL;
      end else begin
        res_d   = op_r;
        flags_d = op_flags;
        done_d  = 1'b1;
      end
    end
`else
    if (alu_start) begin
      res_d   = op_r;
      flags_d = op_flags;
      done_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end
`endif

  assign to_Z      = res_q;
  assign flags     = flags_q;
  assign alu_done  = done_q;
  assign REG_OUT_Y = y_q;

endmodule

// File: doc/alu_y_stage.md
Name: alu_y_stage

Overview:
- Upstream neighbour of the Z result register. Holds the Y operand register, latched from the shared bus, and combines Y with a bus operand under an opcode.
- Produces a registered 16-bit result on to_Z plus flags. Control asserts Z_in on the alu_done cycle to capture the result in Z.
- Single-cycle ops finish in one clock. MUL is a multi-cycle shift-add sequence.

Parameters:
- WIDTH, 16, datapath width; all data ports and registers are WIDTH bits.
- MUL_CYCLES, WIDTH, number of shift-add iterations for MUL. Must equal WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset; clears all state when 0
- bus_in  input  WIDTH  shared bus value; supplies the Y load value and operand B
- Y_in  input  1  load Y from bus_in at posedge
- alu_op  input  4  opcode, sampled with alu_start
- alu_start  input  1  start an operation; A=Y and B=bus_in are sampled at this posedge
- to_Z  output  WIDTH  registered result, feeds Z from_ALU
- alu_busy  output  1  high while MUL is iterating
- alu_done  output  1  one-cycle pulse when to_Z/flags are updated
- flags  output  4  {N,Zf,C,V} registered with to_Z
- REG_OUT_Y  output  WIDTH  Y register contents, for debugging

Behaviour:
- Reset (reset=0, async): Y=0, to_Z=0, flags=0, alu_busy=0, alu_done=0, state=IDLE, MUL iteration counter=0.
- Y register: on posedge with Y_in=1, Y<=bus_in. Independent of alu state. A is snapshotted at start, so a Y load during MUL does not corrupt the running operation.
- States: IDLE, MUL.
- IDLE + alu_start with a non-MUL op: result and flags are registered at that same edge; alu_done=1 for the following cycle; stays in IDLE. Latency is one clock.
- IDLE + alu_start with MUL: snapshot A,B; clear accumulator; alu_busy=1; go to MUL.
- MUL: one shift-add per cycle; counter runs 0..MUL_CYCLES-1. On the last iteration, register the result and flags, drop alu_busy, pulse alu_done, return to IDLE. Start-to-done is MUL_CYCLES+1 edges.
- alu_start while busy: ignored, with no effect on the running operation.
- alu_done and alu_start in the same cycle while IDLE: the new op is accepted, giving back-to-back single-cycle ops at one per clock.
- to_Z and flags hold their last value until the next completion.
- Opcodes (A=Y snapshot, B=bus_in snapshot):
  - 0 ADD A+B
  - 1 SUB A-B
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT B
  - 6 SHL A by 1
  - 7 SHR A logical by 1
  - 8 ASR A by 1
  - 9 PASS B
  - A INC B+1
  - B DEC B-1
  - C MUL, low WIDTH bits of A*B, unsigned
  - D-F reserved: result 0, Zf=1, other flags 0, one-cycle done
- Flags:
  - N = result MSB.
  - Zf = (result==0).
  - ADD/INC: C = carry-out; V = signed overflow.
  - SUB/DEC: C = borrow (1 when the minuend is unsigned-less than the subtrahend); V = signed overflow.
  - Shifts: C = bit shifted out; V=0.
  - Logic/PASS/NOT: C=V=0.
  - MUL: C=V=1 if the upper WIDTH bits of the full product are nonzero.
- Wrap-around: all arithmetic is modulo 2^WIDTH. Examples: 0xFFFF+1=0x0000 with C=1; 0x0000-1=0xFFFF with C=1.
- Reset mid-MUL: abort immediately. to_Z=0, no done pulse, IDLE after reset release.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL is implemented as above.
- Undefined: no multiplier, counter or MUL state is compiled. Opcode C behaves as reserved (result 0, Zf=1, one-cycle done). alu_busy is tied to 0.

Test Plan:
- Reset, then Y_in with bus_in=0x1234 -> REG_OUT_Y=0x1234; to_Z=0, flags=0 until the first start.
- Y=0x7FFF, start ADD with B=0x0001 -> next cycle to_Z=0x8000, N=1, V=1, C=0, alu_done high for exactly one cycle.
- Y=0x0000, start SUB with B=0x0001 -> to_Z=0xFFFF, C=1, N=1. Then back-to-back start XOR with B=0xFFFF and Y=0x00FF -> to_Z=0xFF00 on the next cycle.
- With ALU_MUL_EN: Y=0x0012, start MUL with B=0x0034 -> alu_busy for 16 cycles, then to_Z=0x03A8, C=V=0, done on edge 17. A second alu_start while busy is ignored.
- With ALU_MUL_EN: Y=0x0100, MUL with B=0x0100 -> to_Z=0x0000, Zf=1, C=V=1. Reset pulsed at iteration 8 -> to_Z=0, busy=0, no done.
- Without ALU_MUL_EN: opcode C and opcode F -> one-cycle done, to_Z=0, Zf=1, alu_busy never asserted.
